// File: rtl/alu_seq_pkg.sv
// Shared encodings and defaults for the ALU operand-loading sequencer.
// ST_EXEC is internal and reports as ST_OP on the status LEDs.
package alu_seq_pkg;

  localparam int LEN_DATO_DEF        = 8;
  localparam int LEN_OP_DEF          = 6;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_OP   = 3'd2,
    ST_SHOW = 3'd3,
    ST_EXEC = 3'd4
  } state_t;

  function automatic logic [1:0] state_code(input state_t s);
    return (s == ST_EXEC) ? 2'd2 : s[1:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, one-cycle press pulse.
// Pulse follows a clean raw edge by 2 + DEBOUNCE_CYCLES cycles; no pulse until released once after reset.
module btn_debounce
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_fill;
  logic          r_armed;
  logic          r_level;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = r_sync[1] ^ r_level;
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_armed <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      // Arm only once the synchronizer holds a real sample showing the button up,
      // so a press held across reset never fires.
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync[1]) r_armed <= 1'b1;
      r_pulse <= w_accept && r_sync[1] && r_armed;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Steps operand A, operand B and opcode capture from switches, then latches the ALU result.
// Result reaches o_led two cycles after the opcode-capture pulse; clear aborts to ST_A.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int LEN_DATO        = LEN_DATO_DEF,
  parameter int LEN_OP          = LEN_OP_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [LEN_DATO-1:0] i_switch,
  input  logic                i_btn_next,
  input  logic                i_btn_clear,
  input  logic [LEN_DATO-1:0] i_resultado,
  output logic [LEN_DATO-1:0] o_dato_a,
  output logic [LEN_DATO-1:0] o_dato_b,
  output logic [LEN_OP-1:0]   o_op_code,
  output logic [LEN_DATO-1:0] o_led,
  output logic                o_valid,
  output logic [1:0]          o_state
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_nxt_pulse;
  logic                w_clr_pulse;
  logic [1:0]          w_unused_lvl;
  logic                w_ld_a;
  logic                w_ld_b;
  logic                w_ld_op;
  logic                w_ld_res;
  logic                w_drop_valid;
  logic [LEN_DATO-1:0] r_dato_a;
  logic [LEN_DATO-1:0] r_dato_b;
  logic [LEN_OP-1:0]   r_op_code;
  logic [LEN_DATO-1:0] r_led;
  logic                r_valid;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_next),
    .o_level (w_unused_lvl[0]),
    .o_pulse (w_nxt_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_clear),
    .o_level (w_unused_lvl[1]),
    .o_pulse (w_clr_pulse)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_A;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_a       = 1'b0;
    w_ld_b       = 1'b0;
    w_ld_op      = 1'b0;
    w_ld_res     = 1'b0;
    w_drop_valid = 1'b0;
    // Clear outranks next, including the ST_EXEC result latch.
    if (w_clr_pulse) begin
      w_state_nxt  = ST_A;
      w_drop_valid = 1'b1;
    end else begin
      case (r_state)
        ST_A:    if (w_nxt_pulse) begin w_ld_a  = 1'b1; w_state_nxt = ST_B;    end
        ST_B:    if (w_nxt_pulse) begin w_ld_b  = 1'b1; w_state_nxt = ST_OP;   end
        ST_OP:   if (w_nxt_pulse) begin w_ld_op = 1'b1; w_state_nxt = ST_EXEC; end
        ST_EXEC: begin w_ld_res = 1'b1; w_state_nxt = ST_SHOW; end
        ST_SHOW: if (w_nxt_pulse) begin w_drop_valid = 1'b1; w_state_nxt = ST_A; end
        default: w_state_nxt = ST_A;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dato_a  <= '0;
      r_dato_b  <= '0;
      r_op_code <= '0;
      r_led     <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_ld_a)  r_dato_a  <= i_switch;
      if (w_ld_b)  r_dato_b  <= i_switch;
      if (w_ld_op) r_op_code <= i_switch[LEN_OP-1:0];
      if (w_ld_res) begin
        r_led   <= i_resultado;
        r_valid <= 1'b1;
      end else if (w_drop_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dato_a  = r_dato_a;
  assign o_dato_b  = r_dato_b;
  assign o_op_code = r_op_code;
  assign o_led     = r_led;
  assign o_valid   = r_valid;
  assign o_state   = state_code(r_state);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a 4-cycle debounce and an abstract sequencer model.
module tb_alu_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_switch = 8'h00;
  logic       i_btn_next = 1'b0;
  logic       i_btn_clear = 1'b0;
  logic [7:0] i_resultado;
  logic [7:0] o_dato_a, o_dato_b, o_led;
  logic [5:0] o_op_code;
  logic       o_valid;
  logic [1:0] o_state;

  int checks = 0;
  int failures = 0;

  // Abstract model: position in the A/B/OP/SHOW sequence plus captured values.
  logic [1:0] m_state = 2'd0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_led = 8'h00;
  logic [5:0] m_op = 6'h00;
  logic       m_valid = 1'b0;

  logic [5:0] op_tbl [0:6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02};

  alu_seq_ctrl #(.LEN_DATO(8), .LEN_OP(6), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_switch    (i_switch),
    .i_btn_next  (i_btn_next),
    .i_btn_clear (i_btn_clear),
    .i_resultado (i_resultado),
    .o_dato_a    (o_dato_a),
    .o_dato_b    (o_dato_b),
    .o_op_code   (o_op_code),
    .o_led       (o_led),
    .o_valid     (o_valid),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign i_resultado = alu_ref(o_dato_a, o_dato_b, o_op_code);

  function automatic logic [32:0] obs();
    return {o_state, o_valid, o_led, o_op_code, o_dato_b, o_dato_a};
  endfunction

  function automatic logic [32:0] expv();
    return {m_state, m_valid, m_led, m_op, m_b, m_a};
  endfunction

  task automatic model_next(input logic [7:0] sw);
    case (m_state)
      2'd0: begin m_a = sw; m_state = 2'd1; end
      2'd1: begin m_b = sw; m_state = 2'd2; end
      2'd2: begin
        m_op = sw[5:0];
        m_led = alu_ref(m_a, m_b, m_op);
        m_valid = 1'b1;
        m_state = 2'd3;
      end
      default: begin m_valid = 1'b0; m_state = 2'd0; end
    endcase
  endtask

  task automatic model_clear();
    m_state = 2'd0;
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_valid = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_led = 8'h00;
  endtask

  // Clean press: hold 10 cycles, release 10 cycles.
  task automatic press(input logic nxt, input logic clr, input logic [7:0] sw);
    @(negedge i_clk);
    i_switch = sw;
    i_btn_next = nxt;
    i_btn_clear = clr;
    repeat (10) @(negedge i_clk);
    i_btn_next = 1'b0;
    i_btn_clear = 1'b0;
    repeat (10) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
    repeat (20) @(negedge i_clk);
    checks++;
    if (obs() !== 33'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", obs());
    end
    checks++;
    if (o_state !== 2'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", o_state);
    end
  endtask

  task automatic test_full_sequence();
    @(negedge i_clk);
    i_switch = 8'h05;
    i_btn_next = 1'b1;
    repeat (6) @(negedge i_clk);
    checks++;
    if (o_state !== 2'd0) begin
      failures++; $display("FAIL early_capture got=%0d exp=0", o_state);
    end
    @(negedge i_clk);
    checks++;
    if (o_state !== 2'd1 || o_dato_a !== 8'h05) begin
      failures++; $display("FAIL capture_a state=%0d a=%h exp state=1 a=05", o_state, o_dato_a);
    end
    i_btn_next = 1'b0;
    repeat (10) @(negedge i_clk);
    model_next(8'h05);
    press(1'b1, 1'b0, 8'h03);
    model_next(8'h03);
    @(negedge i_clk);
    i_switch = 8'h20;
    i_btn_next = 1'b1;
    repeat (7) @(negedge i_clk);
    checks++;
    if (o_op_code !== 6'h20 || o_state !== 2'd2 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL exec_cycle op=%h st=%0d v=%b exp op=20 st=2 v=0", o_op_code, o_state, o_valid);
    end
    @(negedge i_clk);
    checks++;
    if (o_led !== 8'h08 || o_valid !== 1'b1 || o_state !== 2'd3) begin
      failures++;
      $display("FAIL result_latency led=%h v=%b st=%0d exp led=08 v=1 st=3", o_led, o_valid, o_state);
    end
    i_btn_next = 1'b0;
    repeat (10) @(negedge i_clk);
    model_next(8'h20);
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL full_sequence got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_bounce();
    logic [7:0] sw;
    logic [1:0] prev;
    int changes;
    press(1'b0, 1'b1, 8'h00);
    model_clear();
    sw = 8'($urandom);
    changes = 0;
    @(negedge i_clk);
    i_switch = sw;
    prev = o_state;
    for (int i = 0; i < 5; i++) begin
      i_btn_next = 1'b1;
      repeat (2) begin
        @(negedge i_clk);
        if (o_state !== prev) begin changes++; prev = o_state; end
      end
      i_btn_next = 1'b0;
      repeat (2) begin
        @(negedge i_clk);
        if (o_state !== prev) begin changes++; prev = o_state; end
      end
    end
    i_btn_next = 1'b1;
    repeat (60) begin
      @(negedge i_clk);
      if (o_state !== prev) begin changes++; prev = o_state; end
    end
    i_btn_next = 1'b0;
    repeat (10) @(negedge i_clk);
    model_next(sw);
    checks++;
    if (changes !== 1) begin
      failures++; $display("FAIL bounce_advances got=%0d exp=1", changes);
    end
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL bounce_state got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_truncation();
    logic [7:0] sw;
    sw = 8'($urandom);
    press(1'b1, 1'b0, sw);
    model_next(sw);
    press(1'b1, 1'b0, 8'hFF);
    model_next(8'hFF);
    checks++;
    if (o_op_code !== 6'h3F) begin
      failures++; $display("FAIL op_truncation got=%h exp=3f", o_op_code);
    end
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL truncation_state got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_clear();
    logic [7:0] sw;
    press(1'b0, 1'b1, 8'h00);
    model_clear();
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL clear_show got=%h exp=%h", obs(), expv());
    end
    for (int i = 0; i < 2; i++) begin
      sw = 8'($urandom);
      press(1'b1, 1'b0, sw);
      model_next(sw);
    end
    press(1'b0, 1'b1, 8'($urandom));
    model_clear();
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL clear_op got=%h exp=%h", obs(), expv());
    end
    sw = 8'($urandom);
    press(1'b1, 1'b0, sw);
    model_next(sw);
    press(1'b1, 1'b1, ~m_b);
    model_clear();
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL clear_and_next got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_clear_exec();
    logic [7:0] a, b;
    a = 8'($urandom_range(1, 100));
    b = 8'($urandom_range(1, 100));
    press(1'b1, 1'b0, a); model_next(a);
    press(1'b1, 1'b0, b); model_next(b);
    @(negedge i_clk);
    i_switch = 8'h20;
    i_btn_next = 1'b1;
    @(negedge i_clk);
    i_btn_clear = 1'b1;
    repeat (10) @(negedge i_clk);
    i_btn_next = 1'b0;
    i_btn_clear = 1'b0;
    repeat (10) @(negedge i_clk);
    m_op = 6'h20;
    model_clear();
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL clear_in_exec got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_random();
    logic [7:0] sw;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        press(1'b0, 1'b1, 8'($urandom));
        model_clear();
      end else begin
        sw = 8'($urandom);
        if (m_state == 2'd2) sw = {2'($urandom), op_tbl[$urandom_range(0, 6)]};
        press(1'b1, 1'b0, sw);
        model_next(sw);
      end
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL random_step%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_show();
    press(1'b0, 1'b1, 8'h00); model_clear();
    press(1'b1, 1'b0, 8'h05); model_next(8'h05);
    press(1'b1, 1'b0, 8'h03); model_next(8'h03);
    press(1'b1, 1'b0, 8'h20); model_next(8'h20);
    checks++;
    if (o_led !== 8'h08 || o_state !== 2'd3) begin
      failures++; $display("FAIL show_before_reset led=%h st=%0d exp led=08 st=3", o_led, o_state);
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    model_reset();
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL reset_in_show got=%h exp=%h", obs(), expv());
    end
    i_reset = 1'b0;
  endtask

  task automatic test_reset_mid_press();
    logic [7:0] sw;
    repeat (4) @(negedge i_clk);
    i_switch = 8'hA5;
    i_btn_next = 1'b1;
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
    repeat (20) @(negedge i_clk);
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL held_through_reset got=%h exp=%h", obs(), expv());
    end
    i_btn_next = 1'b0;
    repeat (10) @(negedge i_clk);
    sw = 8'($urandom);
    press(1'b1, 1'b0, sw);
    model_next(sw);
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL press_after_reset got=%h exp=%h", obs(), expv());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_sequence();
    test_bounce();
    test_truncation();
    test_clear();
    test_clear_exec();
    test_random();
    test_reset_show();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
